qif_tdm_scheduler: RTL and testbench

QIF_TDM_SCHEDULER -- requirements
Module: qif_tdm_scheduler

---
 rtl/qif_pkg.sv | 15 +
 rtl/qif_rr_arbiter.sv | 44 ++++
 rtl/qif_tdm_scheduler.sv | 140 ++++++++++++++
 tb/tb_qif_tdm_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// Shared defaults and FSM state type for the QIF time-multiplexed neuron scheduler.
package qif_pkg;

    localparam int                 N_NEURONS_DEF  = 4;
    localparam logic signed [7:0]  V_RESET_DEF    = -8'sd20;
    localparam logic signed [7:0]  V_PEAK_DEF     = 8'sd50;
    localparam int                 GAIN_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } qif_state_t;

endpackage

// File: rtl/qif_rr_arbiter.sv
// N-way round-robin arbiter: the search starts one slot past the last winner,
// and the pointer only moves when the caller reports that a grant was accepted.
module qif_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_id_o
);

    logic [IW-1:0] last_q;

    // Pick the first requester scanning forward from the slot after the last winner.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(last_q) + 1 + k) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_id_o   = idx;
                found        = 1'b1;
            end
        end
    end

    // Remember the accepted winner; reset points at the last slot so slot 0 wins first.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            last_q <= IW'(N - 1);
        end else if (adv_i) begin
            last_q <= grant_id_o;
        end
    end

endmodule

// File: rtl/qif_tdm_scheduler.sv
// Time-multiplexed quadratic integrate-and-fire neuron update engine.
// One shared datapath serves N_NEURONS membrane registers, one update every 3 cycles.
//
// state | meaning
// IDLE  | waiting for a granted request (ready driven combinationally)
// CALC  | compute saturated V + V^2*gain + I_syn, register result outputs
// WB    | result pulse visible; write V_RESET or the new value to the slot
module qif_tdm_scheduler
    import qif_pkg::*;
#(
    parameter int                N_NEURONS  = N_NEURONS_DEF,
    parameter logic signed [7:0] V_RESET    = V_RESET_DEF,
    parameter logic signed [7:0] V_PEAK     = V_PEAK_DEF,
    parameter int                GAIN_SHIFT = GAIN_SHIFT_DEF,
    localparam int               IW         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_NEURONS-1:0]     req_valid,
    input  logic [8*N_NEURONS-1:0]   req_isyn,
    output logic [N_NEURONS-1:0]     req_ready,
    output logic                     v_mem_valid,
    output logic signed [7:0]        v_mem_out,
    output logic [IW-1:0]            v_mem_id,
    output logic                     spike_valid,
    output logic                     busy
);

    qif_state_t         state_q;
    logic [IW-1:0]      id_q;
    logic signed [7:0]  isyn_q;
    logic signed [7:0]  v_mem_q [N_NEURONS];

    logic               v_mem_valid_q;
    logic signed [7:0]  v_mem_out_q;
    logic [IW-1:0]      v_mem_id_q;
    logic               spike_valid_q;

    logic [N_NEURONS-1:0] grant;
    logic [IW-1:0]        grant_id;
    logic                 hs;
    logic signed [7:0]    isyn_sel;
    logic signed [7:0]    v_sat;
    logic                 spike_d;

    qif_rr_arbiter #(
        .N  (N_NEURONS),
        .IW (IW)
    ) u_arb (
        .clk        (clk),
        .rst_i      (rst_n),
        .req_i      (req_valid),
        .adv_i      (hs),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready   = (state_q == ST_IDLE && en) ? grant : '0;
    assign hs          = |req_ready;
    assign busy        = (state_q != ST_IDLE);
    assign v_mem_valid = v_mem_valid_q;
    assign v_mem_out   = v_mem_out_q;
    assign v_mem_id    = v_mem_id_q;
    assign spike_valid = spike_valid_q;

    // Route the granted slot's I_syn lane to the capture register.
    always_comb begin
        isyn_sel = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (req_ready[k]) begin
                isyn_sel = req_isyn[8*k +: 8];
            end
        end
    end

    // 18-bit signed is enough: V^2 peaks at 16384 and the sum stays well inside.
    always_comb begin
        logic signed [17:0] v_ext;
        logic signed [17:0] i_ext;
        logic signed [17:0] sq;
        logic signed [17:0] sum;
        v_ext = {{10{v_mem_q[id_q][7]}}, v_mem_q[id_q]};
        i_ext = {{10{isyn_q[7]}}, isyn_q};
        sq    = v_ext * v_ext;
        sum   = v_ext + (sq >>> GAIN_SHIFT) + i_ext;
        if (sum > 18'sd127) begin
            v_sat = 8'sd127;
        end else if (sum < -18'sd128) begin
            v_sat = -8'sd128;
        end else begin
            v_sat = sum[7:0];
        end
        spike_d = (v_sat >= V_PEAK);
    end

    // Sequencer, membrane storage and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            id_q          <= '0;
            isyn_q        <= '0;
            v_mem_valid_q <= 1'b0;
            v_mem_out_q   <= '0;
            v_mem_id_q    <= '0;
            spike_valid_q <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem_q[k] <= '0;
            end
        end else begin
            v_mem_valid_q <= 1'b0;
            spike_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        id_q    <= grant_id;
                        isyn_q  <= isyn_sel;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    v_mem_valid_q <= 1'b1;
                    v_mem_out_q   <= v_sat;
                    v_mem_id_q    <= id_q;
                    spike_valid_q <= spike_d;
                    state_q       <= ST_WB;
                end
                ST_WB: begin
                    // spike_valid_q is high exactly during WB, so it doubles as the spike flag.
                    v_mem_q[id_q] <= spike_valid_q ? V_RESET : v_mem_out_q;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qif_tdm_scheduler.sv
// Self-checking bench for qif_tdm_scheduler: directed scenarios followed by
// randomized traffic compared against a transaction-level neuron model.
module tb_qif_tdm_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_isyn = '0;
    logic [3:0]  req_ready;
    logic        v_mem_valid;
    logic [7:0]  v_mem_out;
    logic [1:0]  v_mem_id;
    logic        spike_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs_cyc = 0;

    int vm [4];
    int last_g;

    qif_tdm_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_isyn    (req_isyn),
        .req_ready   (req_ready),
        .v_mem_valid (v_mem_valid),
        .v_mem_out   (v_mem_out),
        .v_mem_id    (v_mem_id),
        .spike_valid (spike_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_winner(input logic en_v, input logic [3:0] mask);
        if (!en_v) return -1;
        for (int k = 1; k <= 4; k++) begin
            int s;
            s = (last_g + k) % 4;
            if (mask[s]) return s;
        end
        return -1;
    endfunction

    function automatic int qif_next(input int v, input int isyn);
        int n;
        n = v + ((v * v) / 4) + isyn;
        if (n > 127) n = 127;
        if (n < -128) n = -128;
        return n;
    endfunction

    task automatic do_reset(input int cycles);
        rst_n = 1'b1;
        en = 1'b0;
        req_valid = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) vm[k] = 0;
        last_g = 3;
    endtask

    // One IDLE decision; on a grant, follow it through CALC and WB (3 cycles total).
    task automatic transact(input logic en_v, input logic [3:0] mask, input logic [31:0] isyn_all,
                            output int g, output int out_o, output int spk_o);
        int isyn, nx, spk;
        logic [7:0] lane;
        en = en_v;
        req_valid = mask;
        req_isyn = isyn_all;
        @(negedge clk);
        g = model_winner(en_v, mask);
        check_val("ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        check_val("ready_onehot", int'($countones(req_ready) <= 1), 1);
        check_val("busy_idle", int'(busy), 0);
        check_val("valid_idle", int'(v_mem_valid), 0);
        out_o = -999;
        spk_o = -1;
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        last_hs_cyc = cyc;
        lane = isyn_all[8*g +: 8];
        isyn = int'($signed(lane));
        nx = qif_next(vm[g], isyn);
        spk = (nx >= 50) ? 1 : 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("busy_calc", int'(busy), 1);
        check_val("ready_calc", int'(req_ready), 0);
        check_val("valid_calc", int'(v_mem_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("valid_wb", int'(v_mem_valid), 1);
        check_val("id_wb", int'(v_mem_id), g);
        check_val("out_wb", int'($signed(v_mem_out)), nx);
        check_val("spike_wb", int'(spike_valid), spk);
        out_o = int'($signed(v_mem_out));
        spk_o = int'(spike_valid);
        vm[g] = spk ? -20 : nx;
        last_g = g;
        @(posedge clk); #1;
    endtask

    initial begin
        int g, o, s, prev_hs;
        int rr_exp [5] = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset(2);
        @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_valid", int'(v_mem_valid), 0);
        check_val("rst_out", int'(v_mem_out), 0);
        check_val("rst_id", int'(v_mem_id), 0);
        check_val("rst_spike", int'(spike_valid), 0);
        check_val("rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;

        // Basic: slot 2, I=10
        transact(1'b1, 4'b0100, 32'h000A_0000, g, o, s);
        check_val("basic_out", o, 10);
        check_val("basic_spike", s, 0);

        // Quadratic growth and spiking on slot 0
        transact(1'b1, 4'b0001, 32'h0000_000A, g, o, s);
        check_val("quad1_out", o, 10);
        transact(1'b1, 4'b0001, 32'h0000_0000, g, o, s);
        check_val("quad2_out", o, 35);
        transact(1'b1, 4'b0001, 32'h0000_0000, g, o, s);
        check_val("quad3_out", o, 127);
        check_val("quad3_spike", s, 1);
        transact(1'b1, 4'b0001, 32'h0000_0000, g, o, s);
        check_val("quad4_out", o, 80);
        check_val("quad4_spike", s, 1);

        // Negative path: slot 1, I=-100
        transact(1'b1, 4'b0010, 32'h0000_9C00, g, o, s);
        check_val("neg_out", o, -100);
        check_val("neg_spike", s, 0);

        // Round-robin with every slot requesting
        do_reset(2);
        prev_hs = 0;
        for (int i = 0; i < 5; i++) begin
            transact(1'b1, 4'b1111, 32'h0101_0101, g, o, s);
            check_val("rr_grant", g, rr_exp[i]);
            if (i > 0) check_val("rr_spacing", last_hs_cyc - prev_hs, 3);
            prev_hs = last_hs_cyc;
        end

        // Enable gating
        for (int i = 0; i < 10; i++) begin
            en = 1'b0;
            req_valid = 4'b1000;
            @(negedge clk);
            check_val("en_block", int'(req_ready), 0);
            @(posedge clk); #1;
        end
        transact(1'b1, 4'b1000, 32'h0500_0000, g, o, s);
        check_val("en_grant", g, 3);

        // Reset during CALC aborts the update
        do_reset(1);
        en = 1'b1;
        req_valid = 4'b0100;
        req_isyn = 32'h0028_0000;
        @(negedge clk);
        check_val("mid_ready", int'(req_ready), 4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) vm[k] = 0;
        last_g = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("mid_no_valid", int'(v_mem_valid), 0);
            @(posedge clk); #1;
        end
        transact(1'b1, 4'b0100, 32'h0000_0000, g, o, s);
        check_val("mid_after_out", o, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        en_r;
            logic [3:0]  m;
            logic [31:0] d;
            en_r = ($urandom_range(0, 3) != 0);
            m = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d = d & 32'h0F0F_0F0F;
            transact(en_r, m, d, g, o, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
